// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared types and helpers for the sample-playback address path.
//   flash_addr_t  : 23-bit flash word address
//   addr_state_t  : playback address controller state
//   step_t        : result of one address step (next address + wrap flag)
//   step_addr()   : next address for a forward/backward step inside a
//                   closed region [lo, hi], wrapping at either boundary
// ---------------------------------------------------------------------------
package audio_pkg;

    localparam int FLASH_ADDR_W = 23;

    typedef logic [FLASH_ADDR_W-1:0] flash_addr_t;

    localparam flash_addr_t START_ADDR_DEFAULT = 23'h000000;
    localparam flash_addr_t END_ADDR_DEFAULT   = 23'h07FFFF;

    typedef enum logic [1:0] {
        S_RUN          = 2'd0,
        S_RESTART_PEND = 2'd1
    } addr_state_t;

    typedef struct packed {
        flash_addr_t addr;
        logic        wrap;
    } step_t;

    // One playback step. dir = 1 walks up, dir = 0 walks down; leaving the
    // region on either side re-enters at the opposite boundary.
    function automatic step_t step_addr(
        input flash_addr_t addr,
        input logic        dir,
        input flash_addr_t lo = START_ADDR_DEFAULT,
        input flash_addr_t hi = END_ADDR_DEFAULT
    );
        step_t s;
        s.wrap = 1'b0;
        if (dir) begin
            if (addr == hi) begin
                s.addr = lo;
                s.wrap = 1'b1;
            end else begin
                s.addr = addr + 1'b1;
            end
        end else begin
            if (addr == lo) begin
                s.addr = hi;
                s.wrap = 1'b1;
            end else begin
                s.addr = addr - 1'b1;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// ---------------------------------------------------------------------------
// edge_detect
// Rising-edge detector built on a registered copy of the input. The pulse
// is high in the cycle the input is high while its registered copy is still
// low, so logic clocked on the same edge reacts one cycle after the rise.
// A level held high yields a single pulse. Reset clears the history, so an
// input already high at reset release is seen as a fresh edge.
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   sig      in  level to watch
//   rise     out 1 while sig is high and was low on the previous clock
// ---------------------------------------------------------------------------
module edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    // NOTE: state uses non-blocking assignments in an always_ff with the
    // async reset in the sensitivity list; blocking here would race with
    // every other flop sampling sig_q on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/flash_address_controller.sv
// ---------------------------------------------------------------------------
// flash_address_controller
// Owns the flash word address used during sample playback. The address moves
// by one word per consumed sample (address_change rising edge), forward or
// backward, wrapping inside [START_ADDR, END_ADDR]. A keyboard restart is
// latched and applied at the next word boundary so the address never changes
// while the flash reader has a read in flight.
//   clk             in   system clock
//   reset_n         in   asynchronous active-low reset
//   kybrd_dir       in   1 = forward, 0 = backward (sampled at each step)
//   kybrd_restart   in   restart request level (rising edge latched)
//   address_change  in   current word consumed (rising edge = one step)
//   flsh_address    out  registered word address to the flash controller
//   wrapped         out  1-cycle pulse when a step crossed a region boundary
//   restart_done    out  1-cycle pulse when a latched restart was applied
//   debug           out  {13'b0, state[1:0], dir_q}
// ---------------------------------------------------------------------------
module flash_address_controller
    import audio_pkg::*;
#(
    parameter int                 ADDR_W     = FLASH_ADDR_W,
    parameter logic [ADDR_W-1:0]  START_ADDR = START_ADDR_DEFAULT,
    parameter logic [ADDR_W-1:0]  END_ADDR   = END_ADDR_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              kybrd_dir,
    input  logic              kybrd_restart,
    input  logic              address_change,
    output logic [ADDR_W-1:0] flsh_address,
    output logic              wrapped,
    output logic              restart_done,
    output logic [15:0]       debug
);

    logic              step_rise;
    logic              restart_rise;
    logic              restart_latch;
    logic              dir_q;
    logic [ADDR_W-1:0] addr_q;
    addr_state_t       state;
    step_t             next_step;

    edge_detect u_step_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sig     (address_change),
        .rise    (step_rise)
    );

    edge_detect u_restart_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sig     (kybrd_restart),
        .rise    (restart_rise)
    );

    // The live direction input steers the step it coincides with; dir_q only
    // records which way the last step went.
    assign next_step = step_addr(addr_q, kybrd_dir, START_ADDR, END_ADDR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q        <= START_ADDR;
            wrapped       <= 1'b0;
            restart_done  <= 1'b0;
            dir_q         <= 1'b1;
            restart_latch <= 1'b0;
            state         <= S_RUN;
        end else begin
            wrapped      <= 1'b0;
            restart_done <= 1'b0;

            // Extra restart edges while one is already latched fold into it.
            if (restart_rise) begin
                restart_latch <= 1'b1;
            end

            case (state)
                S_RUN: begin
                    // A step coinciding with a fresh restart edge is a normal
                    // step; the restart waits for the next word boundary.
                    if (step_rise) begin
                        dir_q   <= kybrd_dir;
                        addr_q  <= next_step.addr;
                        wrapped <= next_step.wrap;
                    end
                    if (restart_rise || restart_latch) begin
                        state <= S_RESTART_PEND;
                    end
                end

                S_RESTART_PEND: begin
                    if (step_rise) begin
                        dir_q         <= kybrd_dir;
                        addr_q        <= kybrd_dir ? START_ADDR : END_ADDR;
                        restart_done  <= 1'b1;
                        restart_latch <= 1'b0;
                        state         <= S_RUN;
                    end
                end

                default: begin
                    // Unused encodings recover to a known playback position.
                    addr_q <= START_ADDR;
                    state  <= S_RUN;
                end
            endcase
        end
    end

    assign flsh_address = addr_q;
    assign debug        = {13'b0, state, dir_q};

endmodule

// File: tb/tb_flash_address_controller.sv
// ---------------------------------------------------------------------------
// tb_flash_address_controller
// Directed scenarios followed by random stimulus, all compared against a
// cycle-level reference model of the playback address behaviour. The model
// tracks the address as an offset into the sample region and moves it with
// modular arithmetic.
// ---------------------------------------------------------------------------
module tb_flash_address_controller;
    import audio_pkg::*;

    localparam flash_addr_t START = START_ADDR_DEFAULT;
    localparam flash_addr_t END   = END_ADDR_DEFAULT;
    localparam longint      REGION_WORDS = longint'(END) - longint'(START) + 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        kybrd_dir = 1'b1;
    logic        kybrd_restart = 1'b0;
    logic        address_change = 1'b0;
    flash_addr_t flsh_address;
    logic        wrapped;
    logic        restart_done;
    logic [15:0] debug;

    int checks = 0;
    int errors = 0;

    // Reference model state
    flash_addr_t m_addr;
    logic        m_wrapped;
    logic        m_done;
    logic        m_dir;
    logic        m_pending;
    logic        m_prev_ac;
    logic        m_prev_rs;

    flash_address_controller dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .kybrd_dir      (kybrd_dir),
        .kybrd_restart  (kybrd_restart),
        .address_change (address_change),
        .flsh_address   (flsh_address),
        .wrapped        (wrapped),
        .restart_done   (restart_done),
        .debug          (debug)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_addr    = START;
        m_wrapped = 1'b0;
        m_done    = 1'b0;
        m_dir     = 1'b1;
        m_pending = 1'b0;
        m_prev_ac = 1'b0;
        m_prev_rs = 1'b0;
    endtask

    // Advance the model across one rising clock edge with the given inputs.
    task automatic model_edge(input logic ac, input logic rs, input logic dir);
        logic   step;
        logic   redge;
        longint off;
        step      = ac && !m_prev_ac;
        redge     = rs && !m_prev_rs;
        m_prev_ac = ac;
        m_prev_rs = rs;
        m_wrapped = 1'b0;
        m_done    = 1'b0;
        if (step && m_pending) begin
            m_addr    = dir ? START : END;
            m_dir     = dir;
            m_done    = 1'b1;
            m_pending = 1'b0;
        end else begin
            if (step) begin
                m_dir = dir;
                off = longint'(m_addr) - longint'(START);
                off = (off + (dir ? 1 : REGION_WORDS - 1)) % REGION_WORDS;
                m_wrapped = dir ? (off == 0) : (off == REGION_WORDS - 1);
                m_addr = flash_addr_t'(longint'(START) + off);
            end
            if (redge) m_pending = 1'b1;
        end
    endtask

    task automatic compare_all();
        check("addr", flsh_address, m_addr);
        check("wrapped", wrapped, m_wrapped);
        check("restart_done", restart_done, m_done);
        check("debug", debug, {13'b0, 1'b0, m_pending, m_dir});
    endtask

    // One clock: drive at a falling edge, model the rising edge, compare at
    // the next falling edge. Entered and left on a falling edge.
    task automatic tick(input logic ac, input logic rs, input logic dir);
        address_change = ac;
        kybrd_restart  = rs;
        kybrd_dir      = dir;
        @(posedge clk);
        model_edge(ac, rs, dir);
        @(negedge clk);
        compare_all();
    endtask

    task automatic pulse(input logic dir);
        tick(1'b1, 1'b0, dir);
        tick(1'b0, 1'b0, dir);
    endtask

    // Reset asserted for one cycle; address_change may be held across it.
    task automatic apply_reset(input logic ac_hold);
        address_change = ac_hold;
        kybrd_restart  = 1'b0;
        kybrd_dir      = 1'b1;
        reset_n        = 1'b0;
        model_reset();
        #1;
        check("rst_addr", flsh_address, START);
        check("rst_wrapped", wrapped, 1'b0);
        check("rst_done", restart_done, 1'b0);
        check("rst_debug", debug, 16'h0001);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        apply_reset(1'b0);

        // Five forward steps from the start of the region.
        for (int i = 1; i <= 5; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            check("fwd_addr", flsh_address, START + flash_addr_t'(i));
            check("fwd_nowrap", wrapped, 1'b0);
            tick(1'b0, 1'b0, 1'b1);
        end

        // Backward wrap at START, then forward wrap at END.
        apply_reset(1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("bwd_wrap_addr", flsh_address, END);
        check("bwd_wrap_flag", wrapped, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        check("bwd_wrap_clear", wrapped, 1'b0);
        pulse(1'b0);
        check("bwd_end_m1", flsh_address, END - 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        check("fwd_to_end", flsh_address, END);
        check("fwd_to_end_nowrap", wrapped, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        check("fwd_wrap_addr", flsh_address, START);
        check("fwd_wrap_flag", wrapped, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        check("fwd_wrap_clear", wrapped, 1'b0);

        // Restart at 0x100: held until the next word boundary.
        apply_reset(1'b0);
        for (int i = 0; i < 'h100; i++) pulse(1'b1);
        check("at_100", flsh_address, 23'h000100);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        check("restart_hold", flsh_address, 23'h000100);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        check("restart_fwd_addr", flsh_address, START);
        check("restart_fwd_done", restart_done, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        check("restart_done_clear", restart_done, 1'b0);
        for (int i = 0; i < 4; i++) pulse(1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        check("restart_bwd_addr", flsh_address, END);
        check("restart_bwd_done", restart_done, 1'b1);
        check("restart_bwd_nowrap", wrapped, 1'b0);
        tick(1'b0, 1'b0, 1'b0);

        // Restart edge in the same cycle as a step at 0x20.
        apply_reset(1'b0);
        for (int i = 0; i < 'h20; i++) pulse(1'b1);
        tick(1'b1, 1'b1, 1'b1);
        check("coincide_step", flsh_address, 23'h000021);
        check("coincide_nodone", restart_done, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        check("coincide_apply", flsh_address, START);
        check("coincide_done", restart_done, 1'b1);
        tick(1'b0, 1'b0, 1'b1);

        // Reset mid-run with address_change held high across release.
        apply_reset(1'b0);
        for (int i = 0; i < 'h41; i++) pulse(1'b1);
        tick(1'b1, 1'b0, 1'b1);
        check("pre_reset_addr", flsh_address, 23'h000042);
        apply_reset(1'b1);
        tick(1'b1, 1'b0, 1'b1);
        check("post_reset_step", flsh_address, START + 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        check("held_level_one_step", flsh_address, START + 1'b1);
        tick(1'b0, 1'b0, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tick(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 11) == 0),
                 1'($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
